// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, with run/step control, halt, memory timeout and retire count.
module cpu_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_halt,
    input  logic        writes_rd,
    input  logic        zero,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_en,
    output logic        pc_branch,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic       ld_q;
    logic       st_q;
    logic       br_q;
    logic       wr_q;
    logic       zero_q;
    logic       step_pend;
    logic [7:0] tmo_cnt;
    logic       go;
    logic       waiting;
    logic       br_zero;

    assign go = run | step_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            br_q      <= 1'b0;
            wr_q      <= 1'b0;
            zero_q    <= 1'b0;
            step_pend <= 1'b0;
            tmo_cnt   <= 8'd0;
            retired   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                ld_q <= is_load;
                st_q <= is_store & ~is_load;
                br_q <= is_branch;
                wr_q <= writes_rd;
            end
            if (state == ST_EXEC) begin
                zero_q <= zero;
            end
            if (ir_load) begin
                step_pend <= 1'b0;
            end else if (step && !run) begin
                step_pend <= 1'b1;
            end
            if (pc_en) begin
                retired <= retired + 32'd1;
            end
            // Counter only runs while a request is stalled in the same state.
            if (waiting && (state_nxt == state)) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end else begin
                tmo_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_en     = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        waiting   = 1'b0;
        br_zero   = zero_q;

        case (state)
            ST_FETCH: begin
                imem_req = go;
                if (go) begin
                    if (imem_ready) begin
                        ir_load   = 1'b1;
                        state_nxt = ST_DECODE;
                    end else begin
                        waiting = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                state_nxt = is_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                br_zero = zero;
                if (ld_q || st_q) begin
                    state_nxt = ST_MEM;
                end else if (wr_q) begin
                    state_nxt = ST_WB;
                end else begin
                    pc_en     = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = st_q;
                if (dmem_ready) begin
                    if (ld_q) begin
                        state_nxt = ST_WB;
                    end else begin
                        pc_en     = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                pc_en     = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase

        // A ready in the limit cycle already cleared waiting, so it wins over the fault.
        if (waiting && (tmo_cnt == TMO_LIM)) begin
            state_nxt = ST_FAULT;
        end

        // Nothing escapes from an instruction aborted by reset.
        if (rst) begin
            imem_req = 1'b0;
            ir_load  = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            pc_en    = 1'b0;
            halted   = 1'b0;
            fault    = 1'b0;
        end

        pc_branch = pc_en & br_q & br_zero;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized instruction
// streams compared against per-instruction latency/strobe expectations.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, step, imem_ready, dmem_ready;
    logic        is_load, is_store, is_branch, is_halt, writes_rd, zero;
    logic        imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_branch, halted, fault;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_halt(is_halt), .writes_rd(writes_rd), .zero(zero),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_en(pc_en), .pc_branch(pc_branch),
        .halted(halted), .fault(fault), .retired(retired)
    );

    task automatic do_reset(input bit r);
        rst = 1'b1; run = r; step = 1'b0;
        is_load = 0; is_store = 0; is_branch = 0; is_halt = 0; writes_rd = 0; zero = 0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drives one instruction (starting in FETCH) and reports what was observed.
    task automatic exec_instr(input bit ld, st, br, wr, zr, input int iw, dw, drop_at,
                              output int nc, ir_n, dr_n, rf_n, pc_n,
                              output bit dwe, brp, rfp, ir0, flt);
        int icnt, dcnt;
        bit done;
        is_load = ld; is_store = st; is_branch = br; writes_rd = wr; is_halt = 0; zero = zr;
        icnt = 0; dcnt = 0; done = 0;
        nc = -1; rf_n = 0; pc_n = 0; dwe = 0; brp = 0; rfp = 0; ir0 = 0; flt = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            imem_ready = (icnt >= iw);
            dmem_ready = (dcnt >= dw);
            if (c == drop_at) run = 1'b0;
            @(negedge clk);
            if (c == 0) ir0 = imem_req & ir_load;
            if (imem_req) icnt++;
            if (dmem_req) begin
                dcnt++;
                if (dmem_we) dwe = 1;
            end
            if (rf_we) rf_n++;
            if (pc_en) begin
                pc_n++; nc = c + 1; brp = pc_branch; rfp = rf_we; done = 1;
            end
            if (fault) begin
                flt = 1; done = 1;
            end
            @(posedge clk); #1;
        end
        ir_n = icnt; dr_n = dcnt;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b1; step = 0;
        is_load = 0; is_store = 0; is_branch = 0; is_halt = 0; writes_rd = 0; zero = 0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, ir_load, pc_en} !== 3'b000) begin
            failures++; $display("FAIL reset_gate: strobes=%b expected 000", {imem_req, ir_load, pc_en});
        end
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_branch, halted, fault} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_branch, halted, fault});
        end
        checks++;
        if (retired !== 32'd0) begin
            failures++; $display("FAIL reset_retired: got %0d expected 0", retired);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        int nc, ir_n, dr_n, rf_n, pc_n;
        bit dwe, brp, rfp, ir0, flt;
        do_reset(1);
        exec_instr(0, 0, 0, 1, 0, 0, 0, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (ir0 !== 1'b1) begin failures++; $display("FAIL alu_ir_load_c0: got %0b expected 1", ir0); end
        checks++;
        if (nc !== 4) begin failures++; $display("FAIL alu_latency: got %0d expected 4", nc); end
        checks++;
        if ({rfp, brp} !== 2'b10) begin failures++; $display("FAIL alu_rf_we_pc_branch: got %b expected 10", {rfp, brp}); end
        checks++;
        if (retired !== 32'd1) begin failures++; $display("FAIL alu_retired: got %0d expected 1", retired); end
    endtask

    task automatic test_branch;
        int nc, ir_n, dr_n, rf_n, pc_n;
        bit dwe, brp, rfp, ir0, flt;
        do_reset(1);
        exec_instr(0, 0, 1, 0, 1, 0, 0, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (nc !== 3 || brp !== 1'b1 || rf_n !== 0) begin
            failures++; $display("FAIL branch_taken: cyc=%0d br=%0b rf=%0d expected 3 1 0", nc, brp, rf_n);
        end
        exec_instr(0, 0, 1, 0, 0, 0, 0, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (nc !== 3 || brp !== 1'b0 || rf_n !== 0 || ir0 !== 1'b1) begin
            failures++;
            $display("FAIL branch_not_taken: cyc=%0d br=%0b rf=%0d ir0=%0b expected 3 0 0 1", nc, brp, rf_n, ir0);
        end
    endtask

    task automatic test_mem;
        int nc, ir_n, dr_n, rf_n, pc_n;
        bit dwe, brp, rfp, ir0, flt;
        do_reset(1);
        exec_instr(1, 0, 0, 1, 0, 0, 3, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (dr_n !== 4 || dwe !== 1'b0 || nc !== 8 || rfp !== 1'b1) begin
            failures++;
            $display("FAIL load_wait: dreq=%0d we=%0b cyc=%0d rf=%0b expected 4 0 8 1", dr_n, dwe, nc, rfp);
        end
        exec_instr(0, 1, 0, 0, 0, 0, 3, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (dr_n !== 4 || dwe !== 1'b1 || nc !== 7 || rf_n !== 0) begin
            failures++;
            $display("FAIL store_wait: dreq=%0d we=%0b cyc=%0d rf=%0d expected 4 1 7 0", dr_n, dwe, nc, rf_n);
        end
        checks++;
        if (retired !== 32'd2) begin failures++; $display("FAIL mem_retired: got %0d expected 2", retired); end
    endtask

    task automatic test_random;
        int nc, ir_n, dr_n, rf_n, pc_n, iw, dw, exp_nc, exp_dr;
        bit dwe, brp, rfp, ir0, flt, ld, st, br, wr, zr, mem, wb;
        logic [31:0] exp_ret;
        do_reset(1);
        exp_ret = 0;
        for (int k = 0; k < 60; k++) begin
            ld = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 2) == 0);
            wr = 1'($urandom_range(0, 1));
            zr = 1'($urandom_range(0, 1));
            iw = $urandom_range(0, 4);
            dw = $urandom_range(0, 4);
            mem = ld | st;
            wb = ld | (!st & wr);
            exp_nc = iw + 1 + 2 + (mem ? dw + 1 : 0) + (wb ? 1 : 0);
            exp_dr = mem ? dw + 1 : 0;
            exp_ret = exp_ret + 1;
            exec_instr(ld, st, br, wr, zr, iw, dw, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
            checks++;
            if (nc !== exp_nc || ir_n !== iw + 1 || dr_n !== exp_dr) begin
                failures++;
                $display("FAIL rand_timing[%0d]: cyc=%0d ireq=%0d dreq=%0d expected %0d %0d %0d",
                         k, nc, ir_n, dr_n, exp_nc, iw + 1, exp_dr);
            end
            checks++;
            if (dwe !== (st & !ld) || rf_n !== int'(wb) || rfp !== wb || brp !== (br & zr) || pc_n !== 1) begin
                failures++;
                $display("FAIL rand_strobes[%0d]: we=%0b rf=%0d rfpc=%0b br=%0b pc=%0d expected %0b %0d %0b %0b 1",
                         k, dwe, rf_n, rfp, brp, pc_n, st & !ld, wb, wb, br & zr);
            end
            checks++;
            if (retired !== exp_ret) begin
                failures++; $display("FAIL rand_retired[%0d]: got %0d expected %0d", k, retired, exp_ret);
            end
        end
    endtask

    task automatic test_step;
        int nc, ir_n, dr_n, rf_n, pc_n, idle_req;
        bit dwe, brp, rfp, ir0, flt;
        do_reset(0);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        exec_instr(0, 0, 0, 1, 0, 0, 0, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (nc !== 4 || retired !== 32'd1) begin
            failures++; $display("FAIL step_one: cyc=%0d retired=%0d expected 4 1", nc, retired);
        end
        idle_req = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req) idle_req++;
            @(posedge clk); #1;
        end
        checks++;
        if (idle_req !== 0) begin failures++; $display("FAIL step_idle: imem_req cycles=%0d expected 0", idle_req); end
        // step while running must not leave a pending step behind
        run = 1'b1; step = 1'b1;
        exec_instr(0, 0, 0, 1, 0, 0, 0, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        run = 1'b0; step = 1'b0;
        idle_req = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req) idle_req++;
            @(posedge clk); #1;
        end
        checks++;
        if (idle_req !== 0 || retired !== 32'd2) begin
            failures++; $display("FAIL step_while_run: imem_req cycles=%0d retired=%0d expected 0 2", idle_req, retired);
        end
    endtask

    task automatic test_run_drop;
        int nc, ir_n, dr_n, rf_n, pc_n, idle_req, n;
        bit dwe, brp, rfp, ir0, flt, req_drop, seen;
        do_reset(1);
        exec_instr(0, 0, 0, 1, 0, 0, 0, 1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        idle_req = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req) idle_req++;
            @(posedge clk); #1;
        end
        checks++;
        if (nc !== 4 || idle_req !== 0) begin
            failures++; $display("FAIL run_drop_mid: cyc=%0d idle_req=%0d expected 4 0", nc, idle_req);
        end
        // drop run during a stalled fetch: counter must restart from zero
        do_reset(1);
        imem_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        run = 1'b0;
        @(negedge clk);
        req_drop = imem_req;
        @(posedge clk); #1;
        run = 1'b1;
        n = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (fault) seen = 1;
            else if (imem_req) n++;
            @(posedge clk); #1;
        end
        checks++;
        if (req_drop !== 1'b0 || n !== 16 || seen !== 1'b1) begin
            failures++;
            $display("FAIL run_drop_wait: req=%0b req_cycles=%0d fault=%0b expected 0 16 1", req_drop, n, seen);
        end
    endtask

    task automatic test_timeout;
        int nc, ir_n, dr_n, rf_n, pc_n, n;
        bit dwe, brp, rfp, ir0, flt, seen, req_at_fault;
        do_reset(1);
        imem_ready = 1'b0;
        n = 0; seen = 0; req_at_fault = 1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (fault) begin
                seen = 1; req_at_fault = imem_req;
            end else if (imem_req) begin
                n++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n !== 16 || seen !== 1'b1 || req_at_fault !== 1'b0) begin
            failures++;
            $display("FAIL imem_timeout: req_cycles=%0d fault=%0b req=%0b expected 16 1 0", n, seen, req_at_fault);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || imem_req !== 1'b1) begin
            failures++; $display("FAIL fault_clear: fault=%0b imem_req=%0b expected 0 1", fault, imem_req);
        end
        @(posedge clk); #1;
        do_reset(1);
        exec_instr(0, 1, 0, 0, 0, 15, 15, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (flt !== 1'b0 || ir_n !== 16 || dr_n !== 16 || nc !== 34) begin
            failures++;
            $display("FAIL ready_wins: fault=%0b ireq=%0d dreq=%0d cyc=%0d expected 0 16 16 34", flt, ir_n, dr_n, nc);
        end
        exec_instr(1, 0, 0, 1, 0, 0, 16, -1, nc, ir_n, dr_n, rf_n, pc_n, dwe, brp, rfp, ir0, flt);
        checks++;
        if (flt !== 1'b1 || pc_n !== 0 || dr_n !== 16 || retired !== 32'd1) begin
            failures++;
            $display("FAIL dmem_timeout: fault=%0b pc=%0d dreq=%0d retired=%0d expected 1 0 16 1", flt, pc_n, dr_n, retired);
        end
    endtask

    task automatic test_halt;
        int first_halt, pcn;
        do_reset(1);
        is_halt = 1'b1;
        first_halt = -1; pcn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (halted && first_halt < 0) first_halt = c;
            if (pc_en) pcn++;
            @(posedge clk); #1;
        end
        checks++;
        if (first_halt !== 2 || pcn !== 0 || retired !== 32'd0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL halt: first=%0d pc=%0d retired=%0d req=%0b expected 2 0 0 0", first_halt, pcn, retired, imem_req);
        end
        is_halt = 1'b0;
    endtask

    task automatic test_rst_mid_mem;
        bit req_before;
        do_reset(1);
        is_load = 1'b1; writes_rd = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        req_before = dmem_req;
        @(posedge clk); #1;
        rst = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_before !== 1'b1 || pc_en !== 1'b0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_mem_abort: dreq_before=%0b pc_en=%0b rf_we=%0b expected 1 0 0", req_before, pc_en, rf_we);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b1 || retired !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_mem_after: dreq=%0b ireq=%0b retired=%0d expected 0 1 0", dmem_req, imem_req, retired);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_random();
        test_step();
        test_run_drop();
        test_timeout();
        test_halt();
        test_rst_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the CPU. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the instruction-memory and data-memory request handshakes. At the end of each instruction it emits the one-cycle update strobe and the branch select to the program counter. It also provides run/single-step debug control, halt detection, a memory-timeout fault and a retired-instruction counter.

## Interface
- TIMEOUT, default 15: maximum cycles a memory request may stay outstanding without ready; legal range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-running fetch.
- step  in  1  one-cycle pulse; when run=0, permits exactly one instruction.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- is_load, is_store, is_branch, is_halt, writes_rd  in  1 each  decoder class flags, valid in the DECODE cycle.
- zero  in  1  ALU zero flag, valid in the EXEC cycle.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  instruction-register load strobe.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable; qualified by dmem_req.
- rf_we  out  1  register-file write strobe.
- pc_en  out  1  program-counter update strobe.
- pc_branch  out  1  1 = PC adds immediate, 0 = PC adds 1; meaningful only with pc_en.
- halted  out  1  sticky halt indication.
- fault  out  1  sticky memory-timeout fault.
- retired  out  32  count of completed instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. Reset enters FETCH.
- Reset values: every output is 0 and retired = 0. The class latches, zero_q, step_pend and the timeout counter are also cleared.
- step_pend is set by step while run=0. It is cleared when ir_load fires.
- go = run | step_pend.
- FETCH:
  - imem_req = go.
  - If imem_req & imem_ready: ir_load=1 for that cycle, then go to DECODE.
- DECODE:
  - Latch the class flags.
  - If is_halt: go to HALT. Otherwise go to EXEC.
- EXEC:
  - zero_q <= zero.
  - If load or store: go to MEM.
  - Else if writes_rd: go to WB.
  - Else: pc_en=1 this cycle, then go to FETCH. This is the branch/no-write path.
- MEM:
  - dmem_req=1; dmem_we = store latch.
  - On dmem_ready, a load goes to WB.
  - On dmem_ready, a store asserts pc_en=1 and goes to FETCH.
- WB:
  - rf_we=1 and pc_en=1, then go to FETCH.
- pc_branch = pc_en & is_branch latch & branch zero. The branch zero is the zero input in the EXEC cycle, or zero_q in later states.
- retired increments by 1 on every pc_en cycle and wraps modulo 2^32.
- HALT: halted=1 and all strobes are 0. The FSM leaves HALT only on rst.
- Timeout:
  - The counter increments each cycle imem_req or dmem_req is high without the matching ready.
  - The counter clears on ready and on every state change.
  - When the counter reaches TIMEOUT, the FSM goes to FAULT next cycle.
- FAULT: fault=1 and all requests and strobes are 0. The FSM leaves FAULT only on rst.
- Conflicting class flags: load takes priority over store; is_halt takes priority over all.

## Timing
- All outputs are registered-state (Moore) decodes, except:
  - ir_load, and pc_en in MEM, are combinational on imem_ready and dmem_ready respectively.
  - pc_branch, when pc_en fires in EXEC, is combinational on the zero input.
- Zero-wait-state latencies, from the first imem_req cycle to pc_en:
  - branch/no-write instruction: 3 cycles.
  - ALU instruction: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- pc_en is asserted exactly once per instruction, always for exactly one cycle.
- run deasserted mid-instruction: the current instruction completes. The next FETCH holds imem_req=0.
- run falling while imem_req=1 and imem_ready=0: imem_req drops and the timeout counter clears.
- step asserted while run=1: ignored, step_pend is not set.
- rst mid-MEM: the next cycle has dmem_req=0 and the FSM is in FETCH. No pc_en or rf_we is produced for the aborted instruction.
- A ready arriving in the same cycle the counter reaches TIMEOUT wins; there is no fault.

## Test plan
- ALU op (writes_rd=1), run=1, imem_ready and dmem_ready tied 1 → imem_req and ir_load in cycle 0; rf_we and pc_en in cycle 3 with pc_branch=0; retired=1.
- Branch with zero=1, then branch with zero=0 → pc_en in cycle 2 with pc_branch=1, then in cycle 5 with pc_branch=0; rf_we never asserted.
- Load with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0; rf_we and pc_en together 1 cycle after dmem_ready; store variant gives dmem_we=1 and pc_en on the dmem_ready cycle.
- run=0 plus one step pulse → exactly one instruction retires (retired 0→1), then imem_req stays 0 for 20 cycles.
- imem_ready held 0 with TIMEOUT=15 → imem_req high for 16 cycles, then fault=1 and imem_req=0; rst clears fault and returns the FSM to FETCH.
- is_halt decoded → halted=1 from cycle 2, pc_en never asserted, retired unchanged; rst asserted during a load's MEM wait → dmem_req=0 the next cycle and retired=0.
